// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sequencer: state encoding,
// op codes and the latency-class decode.
package alu_share_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Ops routed through the adder/subtractor take ARITH_LAT cycles; the rest take one.
    function automatic logic is_arith(input logic [2:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_SBC, OP_SUB, OP_CMP: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the caller stores last_grant.
module alu_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_id,
    output logic gnt_valid
);

    assign gnt_valid = valid0 | valid1;
    // On a tie the requester that did not win last time goes next.
    assign gnt_id    = (valid0 & valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer that time-shares one ALU between two requesters and returns
// each result on a single response channel tagged with the requester id.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ARITH_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             busy
);

    localparam int               CNT_W     = $clog2(ARITH_LAT + 1);
    localparam logic [CNT_W-1:0] ARITH_CNT = CNT_W'(ARITH_LAT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_id;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_id;

    logic               w_gnt_id;
    logic               w_gnt_valid;
    logic [2:0]         w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;

    alu_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (r_last_grant),
        .gnt_id     (w_gnt_id),
        .gnt_valid  (w_gnt_valid)
    );

    assign w_sel_op = w_gnt_id ? req1_op : req0_op;
    assign w_sel_a  = w_gnt_id ? req1_a  : req0_a;
    assign w_sel_b  = w_gnt_id ? req1_b  : req0_b;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid)   w_next_state = EXEC;
            EXEC:    if (r_cnt == '0)   w_next_state = RESP;
            RESP:    if (resp_ready)    w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Gated by rst so ready reads 0 throughout reset even with valid held high.
        if (!rst && r_state == IDLE && w_gnt_valid) begin
            req0_ready = ~w_gnt_id;
            req1_ready = w_gnt_id;
        end
        resp_valid = (r_state == RESP);
        busy       = (r_state == EXEC) || (r_state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_id         <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_op         <= w_sel_op;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_cnt        <= is_arith(w_sel_op) ? ARITH_CNT : '0;
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_data <= alu_y;
                        r_resp_id   <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // The ALU inputs come straight from the latch registers, so they hold between ops.
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign resp_data = r_resp_data;
    assign resp_id   = r_resp_id;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: single-op vector table, backpressure,
// mid-operation reset and tie arbitration, against a small ALU model.
module tb_alu_share_ctrl;

    localparam int W   = 8;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id;
    logic [W-1:0] resp_data;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl #(.WIDTH(W), .ARITH_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .busy       (busy)
    );

    // Bench ALU: adds and subtracts on the arithmetic codes, bitwise ops on the logic codes.
    function automatic logic [W-1:0] alu_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000, 3'b010, 3'b111: return a + b;
            3'b011, 3'b101:         return a - b;
            3'b001:                 return a & b;
            3'b100:                 return a | b;
            default:                return a ^ b;
        endcase
    endfunction

    assign alu_y = alu_model(alu_op, alu_a, alu_b);

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        int         lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(inout int n);
        while (resp_valid !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        if (v.id) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        check("grant_ready", {req1_ready, req0_ready}, v.id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 1;
        check("exec_alu_in", {busy, alu_op, alu_a, alu_b}, {busy ? 1'b1 : 1'b1, v.op, v.a, v.b} & 32'h0 | {1'b1, v.op, v.a, v.b});
        wait_resp(n);
        check("latency", n, v.lat);
        check("resp_data", resp_data, v.y);
        check("resp_id", resp_id, v.id);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("idle_after_resp", {resp_valid, busy}, 0);
        check("alu_op_held", alu_op, v.op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1);
    end

    initial begin
        int   n;
        int   last_cyc;
        int   prev_lat;
        logic seen;
        logic exp_id;

        vecs[0] = '{1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, 3};
        vecs[1] = '{1'b1, 3'b100, 8'hF0, 8'h0F, 8'hFF, 2};
        vecs[2] = '{1'b1, 3'b001, 8'hCC, 8'hAA, 8'h88, 2};
        vecs[3] = '{1'b1, 3'b110, 8'hCC, 8'hAA, 8'h66, 2};
        vecs[4] = '{1'b0, 3'b101, 8'h05, 8'h07, 8'hFE, 3};
        vecs[5] = '{1'b0, 3'b011, 8'h10, 8'h01, 8'h0F, 3};
        vecs[6] = '{1'b1, 3'b010, 8'hFF, 8'h02, 8'h01, 3};
        vecs[7] = '{1'b0, 3'b111, 8'h40, 8'h40, 8'h80, 3};

        // Reset with both requests asserted: nothing may be granted.
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 3'b000; req0_a = 8'h11; req0_b = 8'h22;
        req1_op = 3'b001; req1_a = 8'h33; req1_b = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_resp", {resp_valid, resp_id, resp_data}, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("rst_busy", busy, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_no_req", {busy, req1_ready, req0_ready}, 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Backpressure: response held for five extra cycles while req0 waits.
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 8'h30; req1_b = 8'h03;
        #1;
        check("bp_grant", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        n = 1;
        wait_resp(n);
        check("bp_latency", n, 2);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h02; req0_b = 8'h02;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_hold", {resp_valid, busy, req1_ready, req0_ready, resp_id, resp_data}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33});
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_ready_in_resp", {req1_ready, req0_ready}, 0);
        tick();
        resp_ready = 1'b0;
        check("bp_idle_grant", {resp_valid, busy, req0_ready}, 3'b001);
        tick();
        req0_valid = 1'b0;
        n = 1;
        wait_resp(n);
        check("bp_next_resp", {resp_id, resp_data, n[7:0]}, {1'b0, 8'h04, 8'd3});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Reset asserted mid-EXEC discards the operation.
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 8'h09; req0_b = 8'h03;
        tick();
        req0_valid = 1'b0;
        check("mid_exec_busy", {busy, alu_op}, {1'b1, 3'b011});
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("mid_rst_out", {busy, resp_valid, resp_id, resp_data, req1_ready, req0_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        check("no_resp_after_rst", seen, 0);

        // Tie arbitration right after reset: grants alternate 0,1,0,1 at L+2 spacing.
        req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h02;
        req1_op = 3'b110; req1_a = 8'hFF; req1_b = 8'h0F;
        req0_valid = 1'b1; req1_valid = 1'b1;
        resp_ready = 1'b1;
        last_cyc = 0;
        prev_lat = 0;
        for (int g = 0; g < 4; g++) begin
            exp_id = g[0];
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 12) begin
                tick();
                #1;
                n++;
            end
            check("tie_grant", {req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
            if (g > 0) check("tie_spacing", cyc - last_cyc, prev_lat + 2);
            last_cyc = cyc;
            prev_lat = exp_id ? 1 : LAT;
            tick();
            n = 1;
            wait_resp(n);
            check("tie_resp", {resp_id, resp_data}, exp_id ? {1'b1, 8'hF0} : {1'b0, 8'h03});
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        check("final_idle", {busy, resp_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
